dff_bank_rr_arbiter: RTL and testbench
======================================

Name: dff_bank_rr_arbiter

Overview:
Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop register.
- Up to N_REQ requesters compete for write access to the register.
- The block grants one requester at a time and bounds each tenure to MAX_HOLD cycles.
- The register captures only the owner's data when the owner strobes its write enable.
- It sits between requester logic and any consumer of the shared registered value.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, width of shared register and of each requester's data slice
MAX_HOLD, 4, maximum consecutive grant cycles per tenure (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  request vector, bit i = requester i wants the register
we  input  N_REQ  write strobe per requester, honoured only for the current owner
wdata  input  N_REQ*WIDTH  packed data, slice i = wdata[i*WIDTH +: WIDTH]
gnt  output  N_REQ  registered one-hot grant, all-zero when idle
q  output  WIDTH  shared register contents
upd  output  1  one-cycle pulse, high in the cycle after q was updated
busy  output  1  high while any grant is active (equals |gnt)

Behaviour:
- Reset (rst=1 at a clk edge, priority over everything):
  - gnt=0, q=0, upd=0, busy=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state IDLE.
  - Reset mid-tenure drops the grant at that edge; q clears regardless of we.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, select the first i with req[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
  - Next edge: gnt=onehot(i), hold_cnt=1, state GRANT.
  - Latency from req assertion to gnt is 1 cycle.
- GRANT, owner o:
  - Write: if we[o]=1 in a cycle with gnt[o]=1, then next edge q<=wdata slice o and upd=1; otherwise upd=0 and q holds.
  - we[j] for j!=o is ignored. we[o] is ignored when gnt[o]=0.
  - Release condition: req[o]=0 OR hold_cnt==MAX_HOLD.
  - No release: hold_cnt<=hold_cnt+1 and the grant is held.
  - On release:
    - ptr<=(o+1) mod N_REQ.
    - Re-arbitrate in the same cycle over req, scanning from o+1 mod N_REQ; o itself is lowest priority.
    - Winner found: gnt switches directly to the winner at the next edge (no idle bubble), hold_cnt=1.
    - No winner: gnt=0, state IDLE.
  - A write and a release in the same cycle: the write still occurs (q and upd update at that edge).
- Timeout with o the sole requester: o is re-granted at the next edge, hold_cnt restarts at 1; gnt stays high continuously.
- hold_cnt width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD and never wraps.
- gnt is always one-hot or zero. busy = |gnt.
- ptr wraps from N_REQ-1 to 0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111, we=4'b1111 -> gnt=0, q=0, upd=0, busy=0 throughout; rst=0 -> gnt=4'b0001 one cycle later.
- Single owner write: req=4'b0100, we[2]=1, slice2=8'hA5 -> gnt=4'b0100 after 1 cycle; next cycle q=8'hA5 with upd=1; we[2]=0 -> upd=0, q holds 8'hA5.
- Non-owner ignored: owner 0 granted, we=4'b0010 with slice1=8'h3C -> q unchanged, upd=0.
- Round-robin rotation: req=4'b1111 held high, MAX_HOLD=4 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ..., no idle cycles between tenures.
- Early release and handoff: owner 1 drops req after 2 cycles while req[3]=1 and req[0]=1 -> next edge gnt=4'b1000 (scan from 2), then on release gnt=4'b0001.
- Sole-requester timeout plus mid-tenure reset: req=4'b0001 only -> gnt[0] stays high across the MAX_HOLD boundary; assert rst at hold_cnt=2 with we[0]=1 -> next edge gnt=0, q=0, upd=0.

Source files
------------

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// One requester owns the register at a time. A tenure lasts at most MAX_HOLD
// cycles, and only the owner's write strobe loads its data slice.
module dff_bank_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   upd,
  output logic                   busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   own;
  logic [HW-1:0]   hold_cnt;

  logic [IW-1:0]   nxt_own;
  logic [IW-1:0]   scan_start;
  logic [IW-1:0]   win;
  logic [N_REQ-1:0] win_oh;
  logic            found;
  logic            release_now;

  // Pick the next owner: scan from ptr when idle, or from owner+1 on release,
  // so the current owner is naturally the lowest priority.
  always_comb begin
    nxt_own     = (own == IW'(N_REQ - 1)) ? '0 : own + IW'(1);
    scan_start  = (state == GRANT) ? nxt_own : ptr;
    found       = 1'b0;
    win         = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(scan_start) + k) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    release_now = !req[own] || (hold_cnt == HW'(MAX_HOLD));
  end

  // Arbitration FSM, tenure counter and the shared data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      upd      <= 1'b0;
      ptr      <= '0;
      own      <= '0;
      hold_cnt <= '0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= win_oh;
            own      <= win;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (we[own]) begin
            q   <= wdata[own*WIDTH +: WIDTH];
            upd <= 1'b1;
          end
          if (release_now) begin
            // Hand off directly to the next winner; a sole requester that
            // times out wins again and keeps its grant without a gap.
            ptr <= nxt_own;
            if (found) begin
              gnt      <= win_oh;
              own      <= win;
              hold_cnt <= HW'(1);
            end else begin
              gnt      <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Testbench for dff_bank_rr_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural round-robin model.
module tb_dff_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           upd;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner index (-1 when idle), tenure length so far.
  int         m_own = -1;
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [W-1:0] m_q = '0;
  logic       m_upd = 1'b0;

  dff_bank_rr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .q(q), .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int first_from(int start, logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_own = -1; m_cnt = 0; m_ptr = 0; m_q = '0; m_upd = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (m_own < 0) begin
        m_own = first_from(m_ptr, req);
        m_cnt = (m_own >= 0) ? 1 : 0;
      end else begin
        if (we[m_own]) begin
          m_q   = wdata[m_own*W +: W];
          m_upd = 1'b1;
        end
        if (!req[m_own] || m_cnt == MH) begin
          m_ptr = (m_own + 1) % N;
          m_own = first_from(m_ptr, req);
          m_cnt = (m_own >= 0) ? 1 : 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sees at the edge;
  // outputs are examined 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; wdata = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; we = 4'b1111; wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      cyc();
      checks++;
      if (gnt !== 4'b0000 || q !== 8'h00 || upd !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b q=%h upd=%b busy=%b, required 0000/00/0/0", gnt, q, upd, busy);
      end
    end
    rst = 1'b0; we = '0;
    cyc();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_grant: gnt=%b busy=%b, required 0001/1", gnt, busy);
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    req = 4'b0100; we = 4'b0100; wdata = '0; wdata[2*W +: W] = 8'hA5;
    cyc();
    checks++;
    if (gnt !== 4'b0100 || upd !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL single_grant: gnt=%b upd=%b q=%h, required 0100/0/00", gnt, upd, q);
    end
    cyc();
    checks++;
    if (q !== 8'hA5 || upd !== 1'b1) begin
      errors++;
      $display("FAIL single_write: q=%h upd=%b, required a5/1", q, upd);
    end
    we = '0; wdata[2*W +: W] = 8'h11;
    cyc();
    checks++;
    if (q !== 8'hA5 || upd !== 1'b0 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_hold: q=%h upd=%b gnt=%b, required a5/0/0100", q, upd, gnt);
    end
  endtask

  task automatic test_non_owner();
    do_reset();
    req = 4'b0001; we = '0;
    cyc();
    we = 4'b0010; wdata = '0; wdata[1*W +: W] = 8'h3C;
    cyc();
    checks++;
    if (q !== 8'h00 || upd !== 1'b0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL non_owner_ignored: q=%h upd=%b gnt=%b, required 00/0/0001", q, upd, gnt);
    end
    we = '0;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1111; we = '0;
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] exp;
      cyc();
      exp = 4'b0001 << ((k / MH) % N);
      checks++;
      if (gnt !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: gnt=%b busy=%b, required %b/1", k, gnt, busy, exp);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    req = 4'b0010; we = '0;
    cyc();
    cyc();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL handoff_owner1: gnt=%b, required 0010", gnt);
    end
    req = 4'b1001;
    for (int k = 0; k < MH; k++) begin
      cyc();
      checks++;
      if (gnt !== 4'b1000) begin
        errors++;
        $display("FAIL handoff_to3[%0d]: gnt=%b, required 1000", k, gnt);
      end
    end
    cyc();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL handoff_to0: gnt=%b, required 0001", gnt);
    end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    req = 4'b0001; we = 4'b0001; wdata = '0; wdata[0 +: W] = 8'h5A;
    // Six cycles: tenure counts 1,2,3,4 then re-grant 1,2.
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: gnt=%b, required 0001", k, gnt);
      end
    end
    checks++;
    if (q !== 8'h5A) begin
      errors++;
      $display("FAIL timeout_q: q=%h, required 5a", q);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = '0; we = '0;
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h00 || upd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midtenure_reset: gnt=%b q=%h upd=%b busy=%b, required 0000/00/0/0", gnt, q, upd, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 59) == 0);
      req   = 4'($urandom) & 4'($urandom | $urandom);
      we    = 4'($urandom);
      wdata = $urandom;
      cyc();
      checks++;
      if (gnt !== m_gnt() || q !== m_q || upd !== m_upd || busy !== (m_own >= 0)
          || !$onehot0(gnt)) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b q=%h upd=%b busy=%b, required %b/%h/%b/%b",
                 k, gnt, q, upd, busy, m_gnt(), m_q, m_upd, (m_own >= 0));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; wdata = '0;
    test_reset();
    test_single_owner();
    test_non_owner();
    test_rotation();
    test_handoff();
    test_timeout_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
